// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC arbiter slice.
// Function selects are one-hot; anything else is treated as a bad command.
package cordic_pkg;

   localparam int unsigned RES_W = 16;

   localparam logic [3:0] SEL_SIN  = 4'b0001;
   localparam logic [3:0] SEL_COS  = 4'b0010;
   localparam logic [3:0] SEL_TAN  = 4'b0100;
   localparam logic [3:0] SEL_ATAN = 4'b1000;

   typedef enum logic {
      REQ_R0 = 1'b0,
      REQ_R1 = 1'b1
   } req_id_t;

   function automatic logic is_onehot(input logic [3:0] sel);
      return (sel == SEL_SIN) || (sel == SEL_COS) || (sel == SEL_TAN) || (sel == SEL_ATAN);
   endfunction

endpackage

// File: rtl/cordic_arbiter_if.sv
// One requester channel: command handshake plus the unbackpressured result pulse.
interface cordic_arbiter_if;
   import cordic_pkg::*;

   logic             valid;
   logic             ready;
   logic [15:0]      angle;
   logic [15:0]      another;
   logic [3:0]       select;
   logic             rsp_valid;
   logic [RES_W-1:0] rsp_data;

   modport master (
      output valid, angle, another, select,
      input  ready, rsp_valid, rsp_data
   );

   modport slave (
      input  valid, angle, another, select,
      output ready, rsp_valid, rsp_data
   );

endinterface

// File: rtl/cordic_tag_fifo.sv
// In-order FIFO of requester ids, one entry per CORDIC operation in flight.
module cordic_tag_fifo
   import cordic_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  req_id_t       push_id,
   input  logic          pop,
   output req_id_t       pop_id,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   req_id_t        mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic           do_push;
   logic           do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign pop_id  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_id;
      end
   end

   // DEPTH is a power of two, so the pointers wrap on their own.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (do_push && !do_pop) begin
            count <= count + CW'(1);
         end else if (do_pop && !do_push) begin
            count <= count - CW'(1);
         end
      end
   end

endmodule

// File: rtl/cordic_arbiter.sv
// Round-robin sharing of one CORDIC between two requesters; a tag FIFO routes
// each in-order result back to the requester that issued it.
module cordic_arbiter
   import cordic_pkg::*;
#(
   parameter int unsigned DEPTH        = 8,
   parameter int unsigned FLUSH_CYCLES = 16,
   parameter int unsigned CW           = $clog2(DEPTH + 1)
) (
   input  logic                clk,
   input  logic                rst,
   cordic_arbiter_if.slave     r0,
   cordic_arbiter_if.slave     r1,
   output logic                cordic_valid,
   output logic [15:0]         cordic_angle,
   output logic [15:0]         cordic_another,
   output logic [3:0]          cordic_select,
   input  logic [RES_W-1:0]    cordic_out,
   input  logic                cordic_out_valid,
   output logic [CW-1:0]       outstanding,
   output logic                bad_cmd,
   output logic                orphan_err
);

   localparam int unsigned FW = $clog2(FLUSH_CYCLES + 2);

   req_id_t       rr_ptr;
   req_id_t       pop_id;
   req_id_t       grant_id;
   logic          elig0;
   logic          elig1;
   logic          grant0;
   logic          grant1;
   logic          granted;
   logic          sel_ok;
   logic          push;
   logic          pop;
   logic          fifo_full;
   logic          fifo_empty;
   logic [15:0]   g_angle;
   logic [15:0]   g_another;
   logic [3:0]    g_select;
   logic [FW-1:0] flush_cnt;

   // Bad selects never consume a slot, so they stay eligible when the FIFO is full.
   always_comb begin
      elig0     = r0.valid && (!fifo_full || !is_onehot(r0.select));
      elig1     = r1.valid && (!fifo_full || !is_onehot(r1.select));
      grant0    = elig0 && (!elig1 || rr_ptr == REQ_R0);
      grant1    = elig1 && (!elig0 || rr_ptr == REQ_R1);
      granted   = grant0 || grant1;
      grant_id  = grant1 ? REQ_R1 : REQ_R0;
      g_angle   = grant1 ? r1.angle   : r0.angle;
      g_another = grant1 ? r1.another : r0.another;
      g_select  = grant1 ? r1.select  : r0.select;
      sel_ok    = is_onehot(g_select);
      push      = granted && sel_ok;
      pop       = cordic_out_valid && !fifo_empty;
   end

   assign r0.ready = grant0;
   assign r1.ready = grant1;

   cordic_tag_fifo #(
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_tag_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .push_id (grant_id),
      .pop     (pop),
      .pop_id  (pop_id),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (outstanding)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         cordic_valid   <= 1'b0;
         cordic_angle   <= '0;
         cordic_another <= '0;
         cordic_select  <= '0;
         bad_cmd        <= 1'b0;
         orphan_err     <= 1'b0;
         rr_ptr         <= REQ_R0;
         r0.rsp_valid   <= 1'b0;
         r0.rsp_data    <= '0;
         r1.rsp_valid   <= 1'b0;
         r1.rsp_data    <= '0;
         flush_cnt      <= FW'(FLUSH_CYCLES);
      end else begin
         cordic_valid <= push;
         bad_cmd      <= granted && !sel_ok;
         if (push) begin
            cordic_angle   <= g_angle;
            cordic_another <= g_another;
            cordic_select  <= g_select;
         end
         if (grant0) begin
            rr_ptr <= REQ_R1;
         end else if (grant1) begin
            rr_ptr <= REQ_R0;
         end
         r0.rsp_valid <= pop && (pop_id == REQ_R0);
         r1.rsp_valid <= pop && (pop_id == REQ_R1);
         if (pop && pop_id == REQ_R0) begin
            r0.rsp_data <= cordic_out;
         end
         if (pop && pop_id == REQ_R1) begin
            r1.rsp_data <= cordic_out;
         end
         if (flush_cnt != '0) begin
            flush_cnt <= flush_cnt - FW'(1);
         end
         // Results with no owner are only errors once pre-reset ops have drained.
         if (cordic_out_valid && fifo_empty && flush_cnt == '0) begin
            orphan_err <= 1'b1;
         end
      end
   end

endmodule

// File: doc/cordic_arbiter.md
Name: cordic_arbiter

Overview:
- Shares the single CORDIC coprocessor between two requesters, e.g. CPU register interface (r0) and DMA/sequencer (r1).
- Round-robin arbitration grants at most one command per cycle and drives the CORDIC command inputs from registers.
- An in-order tag FIFO records which requester owns each in-flight operation, so each CORDIC result returns to its issuer.
- Sits between the bus-side requesters and the CORDIC top-level.

Parameters:
- DEPTH, 8: maximum in-flight CORDIC operations (tag FIFO depth); power of two, 2..32.
- FLUSH_CYCLES, 16: cycles after reset during which stray CORDIC results are silently dropped; must be at least the CORDIC pipeline latency.
- CW, $clog2(DEPTH+1): width of the outstanding count.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rN_valid  in  1  command valid from requester N (N = 0, 1)
- rN_ready  out  1  command accepted this cycle (combinational grant)
- rN_angle  in  16  angle, signed integer degrees, pre-constrained to 0..90
- rN_another  in  16  second operand (arctan)
- rN_select  in  4  one-hot function select: bit0 sin, bit1 cos, bit2 tan, bit3 arctan
- rN_rsp_valid  out  1  result valid pulse for requester N
- rN_rsp_data  out  16  result, Q7.8 two's complement
- cordic_valid  out  1  command strobe to CORDIC
- cordic_angle  out  16  to CORDIC in_angle
- cordic_another  out  16  to CORDIC another
- cordic_select  out  4  to CORDIC select
- cordic_out  in  16  CORDIC result
- cordic_out_valid  in  1  CORDIC result strobe
- outstanding  out  CW  in-flight count
- bad_cmd  out  1  one-cycle pulse: non-one-hot select accepted and dropped
- orphan_err  out  1  sticky: result arrived with empty tag FIFO after the flush window

Behaviour:
- Reset (rst=1 at a clk edge) clears:
  - all outputs;
  - tag FIFO pointers and outstanding;
  - orphan_err;
  - round-robin pointer, to r0 priority.
- Reset also loads the flush counter with FLUSH_CYCLES.
- Eligibility: a requester is eligible when rN_valid=1 and (outstanding < DEPTH or its select is non-one-hot).
- Grant:
  - Exactly one eligible requester is granted.
  - If both are eligible, the pointer picks one; the pointer then moves to the other requester.
  - The pointer is unchanged when nothing is granted.
  - rN_ready = grant_N, combinational from valid, select, outstanding and pointer.
- Issue, for a granted one-hot command:
  - cordic_valid=1 next cycle, with angle/another/select registered.
  - The requester id is pushed into the tag FIFO in the same cycle.
  - Latency from handshake to CORDIC command is 1 cycle.
  - cordic_valid is low on all other cycles.
  - Back-to-back issue every cycle is allowed.
- Bad command, for a granted non-one-hot select (including 0000):
  - Accepted (ready=1) and not issued.
  - No FIFO push; bad_cmd pulses next cycle.
- Return path on cordic_out_valid=1 with the FIFO non-empty:
  - Pop the tag.
  - Next cycle, rX_rsp_valid=1 and rX_rsp_data=cordic_out for the popped id X.
  - The other requester's rsp_valid stays 0.
  - rsp_data holds its last value when valid is low.
- Results are strictly in order; no response backpressure — requesters must accept rsp_valid.
- Simultaneous push and pop: outstanding unchanged, both operations performed.
  - A full FIFO with a pop in the same cycle still blocks a grant that cycle; eligibility uses the registered count.
- Empty FIFO with cordic_out_valid:
  - The result is dropped.
  - If the flush counter is nonzero, the drop is silent.
  - Otherwise orphan_err is set, and it is cleared only by rst.
- Flush counter decrements each cycle to 0.
  - Commands are still accepted during the flush window.
  - Aborted in-flight ops from before the reset may return while the FIFO is empty, and are dropped silently.
- outstanding equals the FIFO occupancy and is never above DEPTH.

Decomposition:
- Package cordic_pkg holds:
  - SEL_SIN/SEL_COS/SEL_TAN/SEL_ATAN one-hot constants;
  - the requester-id typedef;
  - the result width constant of 16.
- One natural sub-module, cordic_tag_fifo: synchronous FIFO, width 1 (id), depth DEPTH, with push/pop/full/empty/count.

Test Plan:
- Single request, r0: angle=30, sel=0001 -> cordic_valid with angle=30 one cycle after handshake; model returns 0x0080 -> r0_rsp_valid with data 0x0080 one cycle after cordic_out_valid; r1_rsp_valid stays 0.
- Contention: both valid for 4 cycles -> grants in order r0,r1,r0,r1; responses routed to the matching requester in issue order.
- Credit limit: DEPTH=8, CORDIC latency held at 20 cycles, r1 streaming -> 8 accepts, then ready=0 with outstanding=8; the first result frees one slot, and the next accept follows one cycle later.
- Bad select: r0 sel=0000, then r0 sel=0110 -> both accepted, no cordic_valid, bad_cmd pulses twice, outstanding stays 0.
- Reset mid-operation: 3 ops in flight, rst for 1 cycle, and the 3 results arrive within 16 cycles -> no rsp_valid, orphan_err=0. A stray result at cycle 20 after reset -> orphan_err=1.
- Simultaneous issue and return with the FIFO at DEPTH-1 -> push and pop in the same cycle; outstanding holds at DEPTH-1 and routing stays correct.
